ln_out_packer: RTL

- Receive end of the LayerNorm output stream: consumes the int8 mData stream (valid/ready, with mLast) from the LayerNorm top.
- Packs bytes into 64-bit words for DMA write-back, one token row at a time.
- Counts tokens and channels itself and generates the word-level last flag.
- Checks the upstream last flag against its own counters.

---
 rtl/ln_out_packer_if.sv | 37 +++
 rtl/ln_out_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ln_out_packer_if.sv
// =============================================================================
// Module      : ln_out_packer_if
// Description : Byte-stream input and packed-word output handshake bundle
//               for ln_out_packer. The slave modport is the packer's view;
//               the master modport is the view of the surrounding logic.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface ln_out_packer_if #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 64
);
   localparam int c_LANES = OUT_WIDTH / IN_WIDTH;

   logic                 sData_valid;
   logic                 sData_ready;
   logic [IN_WIDTH-1:0]  sData_payload;
   logic                 sLast;
   logic                 mData_valid;
   logic                 mData_ready;
   logic [OUT_WIDTH-1:0] mData_payload;
   logic [c_LANES-1:0]   mKeep;
   logic                 mLast;

   modport master (
      output sData_valid, sData_payload, sLast, mData_ready,
      input  sData_ready, mData_valid, mData_payload, mKeep, mLast
   );

   modport slave (
      input  sData_valid, sData_payload, sLast, mData_ready,
      output sData_ready, mData_valid, mData_payload, mKeep, mLast
   );
endinterface

`default_nettype wire

// File: rtl/ln_out_packer.sv
// =============================================================================
// Module      : ln_out_packer
// Description : Packs the int8 LayerNorm output stream into 64-bit words, one
//               token row at a time, generates the word-level last flag from
//               its own channel/token counters and flags upstream sLast
//               mismatches. Optional LN_PACK_BYTECOUNT_EN adds frame_bytes.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module ln_out_packer #(
   parameter int IN_WIDTH   = 8,
   parameter int OUT_WIDTH  = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        start,
   input  wire logic [9:0]  Channel_Nums,
   input  wire logic [19:0] Token_Nums,
`ifdef LN_PACK_BYTECOUNT_EN
   output logic [29:0]      frame_bytes,
`endif
   output logic             done,
   output logic             last_err,
   ln_out_packer_if.slave   io
);

   localparam int c_LANES  = OUT_WIDTH / IN_WIDTH;
   localparam int c_LANE_W = $clog2(c_LANES);
   localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W  = c_PTR_W + 1;

   localparam logic [c_LANE_W-1:0] c_LANE_MAX  = c_LANE_W'(c_LANES - 1);
   localparam logic [c_CNT_W-1:0]  c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   logic [1:0]           r_state;
   logic [9:0]           r_ch_nums;
   logic [19:0]          r_tok_nums;
   logic [9:0]           r_ch_cnt;
   logic [19:0]          r_tok_cnt;
   logic [c_LANE_W-1:0]  r_lane;
   logic [OUT_WIDTH-1:0] r_pack;
   logic                 r_last_err;

   logic [OUT_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [c_LANES-1:0]   r_fifo_keep [FIFO_DEPTH];
   logic                 r_fifo_last [FIFO_DEPTH];
   logic [c_PTR_W-1:0]   r_wptr;
   logic [c_PTR_W-1:0]   r_rptr;
   logic [c_CNT_W-1:0]   r_count;

   logic                 w_start_ok;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_accept;
   logic                 w_pop;
   logic                 w_row_end;
   logic                 w_last_row;
   logic                 w_final;
   logic                 w_push;
   logic [OUT_WIDTH-1:0] w_word;
   logic [c_LANES-1:0]   w_keep;

   assign w_start_ok = (r_state == c_IDLE) && start;
   assign w_full     = (r_count == c_FIFO_FULL);
   assign w_empty    = (r_count == '0);

   // Input is only taken while a flush can always find a free FIFO slot.
   assign io.sData_ready = (r_state == c_RUN) && !w_full;
   assign w_accept       = io.sData_valid && io.sData_ready;
   assign w_pop          = io.mData_valid && io.mData_ready;

   assign w_row_end  = (r_ch_cnt == r_ch_nums - 10'd1);
   assign w_last_row = (r_tok_cnt == r_tok_nums - 20'd1);
   assign w_final    = w_row_end && w_last_row;
   assign w_push     = w_accept && ((r_lane == c_LANE_MAX) || w_row_end);

   // Merge the incoming byte into the pack register; lanes above stay zero.
   always_comb begin
      w_word = r_pack;
      w_word[r_lane*IN_WIDTH +: IN_WIDTH] = io.sData_payload;
   end

   // Byte enables cover lanes 0..r_lane of the word being formed.
   always_comb begin
      w_keep = '0;
      for (int i = 0; i < c_LANES; i++) begin
         w_keep[i] = (c_LANE_W'(i) <= r_lane);
      end
   end

   // Frame sequencing: IDLE -> RUN -> DRAIN -> DONE, empty frames skip to DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_IDLE;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  if ((Channel_Nums == 10'd0) || (Token_Nums == 20'd0)) begin
                     r_state <= c_DONE;
                  end else begin
                     r_state <= c_RUN;
                  end
               end
            end
            c_RUN: begin
               if (w_accept && w_final) begin
                  r_state <= c_DRAIN;
               end
            end
            c_DRAIN: begin
               if (w_empty) begin
                  r_state <= c_DONE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Frame geometry is captured once per accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ch_nums  <= '0;
         r_tok_nums <= '0;
      end else if (w_start_ok) begin
         r_ch_nums  <= Channel_Nums;
         r_tok_nums <= Token_Nums;
      end
   end

   // Channel/token/lane counters and the partial-word pack register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ch_cnt  <= '0;
         r_tok_cnt <= '0;
         r_lane    <= '0;
         r_pack    <= '0;
      end else if (w_start_ok) begin
         r_ch_cnt  <= '0;
         r_tok_cnt <= '0;
         r_lane    <= '0;
         r_pack    <= '0;
      end else if (w_accept) begin
         if (w_push) begin
            r_lane <= '0;
            r_pack <= '0;
         end else begin
            r_lane <= r_lane + c_LANE_W'(1);
            r_pack <= w_word;
         end
         if (w_row_end) begin
            r_ch_cnt  <= '0;
            r_tok_cnt <= r_tok_cnt + 20'd1;
         end else begin
            r_ch_cnt  <= r_ch_cnt + 10'd1;
         end
      end
   end

   // Sticky flag: upstream sLast disagrees with the internal final-byte position.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_err <= 1'b0;
      end else if (w_start_ok) begin
         r_last_err <= 1'b0;
      end else if (w_accept && (io.sLast != w_final)) begin
         r_last_err <= 1'b1;
      end
   end

   // Output word FIFO storage and pointers; push and pop may coincide.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_keep[i] <= '0;
            r_fifo_last[i] <= 1'b0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wptr] <= w_word;
            r_fifo_keep[r_wptr] <= w_keep;
            r_fifo_last[r_wptr] <= w_final;
            r_wptr              <= r_wptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_W'(1);
         end
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

`ifdef LN_PACK_BYTECOUNT_EN
   logic [29:0] r_frame_bytes;

   // Bytes accepted in the current frame; held after done until next start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frame_bytes <= '0;
      end else if (w_start_ok) begin
         r_frame_bytes <= '0;
      end else if (w_accept) begin
         r_frame_bytes <= r_frame_bytes + 30'd1;
      end
   end

   assign frame_bytes = r_frame_bytes;
`endif

   assign io.mData_valid   = !w_empty;
   assign io.mData_payload = r_fifo_data[r_rptr];
   assign io.mKeep         = r_fifo_keep[r_rptr];
   assign io.mLast         = r_fifo_last[r_rptr];
   assign done             = (r_state == c_DONE);
   assign last_err         = r_last_err;

endmodule

`default_nettype wire
